// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Definitions shared by the coin input encoder and the vending-machine FSM.
//   CODE_*        2-bit coin codes carried on coin_code / the FSM's ip input
//   enc_state_t   encoder arbitration FSM state
//   coin_priority maps simultaneous press events to a single code
// -----------------------------------------------------------------------------
package vend_pkg;

   localparam logic [1:0] CODE_IDLE   = 2'b00;
   localparam logic [1:0] CODE_NICKEL = 2'b01;
   localparam logic [1:0] CODE_DIME   = 2'b10;
   localparam logic [1:0] CODE_CLEAR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // waiting for a press event
      ST_EMIT = 2'b01,   // coin_code carries the accepted code this cycle
      ST_HOLD = 2'b10    // waiting for every button to release
   } enc_state_t;

   // Clear outranks dime, dime outranks nickel; lower-priority events that
   // arrive on the same cycle are dropped, not deferred.
   function automatic logic [1:0] coin_priority(input logic nickel,
                                                input logic dime,
                                                input logic clear);
      logic [1:0] code;
      code = CODE_IDLE;
      if (clear)
         code = CODE_CLEAR;
      else if (dime)
         code = CODE_DIME;
      else if (nickel)
         code = CODE_NICKEL;
      return code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a counting debouncer for one push-button.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive differing samples needed to accept a change (>= 2)
//   CNT_W            counter width, must hold DEBOUNCE_CYCLES-1
// Ports
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   raw    in   button level, asynchronous to clk, already active-high
//   level  out  debounced level
//   rise   out  one-cycle pulse, one cycle after level goes 0 -> 1
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;    // [0] metastability stage, [1] usable sample
   logic [CNT_W-1:0] cnt;
   logic             level_d;   // level delayed one cycle for edge detection

   // NOTE: every register here uses <= so each flop samples the pre-edge value
   // of its neighbours; blocking = would collapse the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b00;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         level_d <= level;
         rise    <= level & ~level_d;

         if (sync_q[1] == level) begin
            // Agreement (including a bounce back) restarts the count.
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // This sample would be the DEBOUNCE_CYCLES-th differing one.
            level <= sync_q[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/coin_input_encoder.sv
// -----------------------------------------------------------------------------
// coin_input_encoder
// Turns the raw nickel / dime / clear push-buttons into single-cycle 2-bit
// coin codes for the vending FSM. Each button is synchronised and debounced,
// simultaneous presses are arbitrated clear > dime > nickel, and one code is
// emitted per accepted press. After a code, further presses are ignored until
// every button has released.
//
// Build option
//   COIN_ENC_ACTIVE_LOW_EN  defined: button pins are active-low and inverted
//                           before synchronisation; undefined: active-high.
// Parameters
//   DEBOUNCE_CYCLES  stable samples required to accept a level change (>= 2)
//   CNT_W            debounce counter width
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   btn_nickel  in   raw nickel button
//   btn_dime    in   raw dime button
//   btn_clear   in   raw clear / end-of-transaction button
//   coin_code   out  registered code: 00 idle, 01 nickel, 10 dime, 11 clear
//   busy        out  high while an accepted press waits for all releases
// -----------------------------------------------------------------------------
module coin_input_encoder
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_nickel,
   input  logic       btn_dime,
   input  logic       btn_clear,
   output logic [1:0] coin_code,
   output logic       busy
);

   // ---------------------------------------------------------------------------
   // Pin polarity: everything downstream sees active-high levels.
   // ---------------------------------------------------------------------------
   logic raw_nickel;
   logic raw_dime;
   logic raw_clear;

`ifdef COIN_ENC_ACTIVE_LOW_EN
   // Inverting ahead of the synchroniser makes its reset value of 0 equal
   // to an unpressed pin reading 1.
   assign raw_nickel = ~btn_nickel;
   assign raw_dime   = ~btn_dime;
   assign raw_clear  = ~btn_clear;
`else
   assign raw_nickel = btn_nickel;
   assign raw_dime   = btn_dime;
   assign raw_clear  = btn_clear;
`endif

   // ---------------------------------------------------------------------------
   // Per-button synchroniser + debouncer
   // ---------------------------------------------------------------------------
   logic level_nickel, rise_nickel;
   logic level_dime,   rise_dime;
   logic level_clear,  rise_clear;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_nickel (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_nickel),
      .level (level_nickel),
      .rise  (rise_nickel)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_dime (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_dime),
      .level (level_dime),
      .rise  (rise_dime)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_clear),
      .level (level_clear),
      .rise  (rise_clear)
   );

   // ---------------------------------------------------------------------------
   // Priority arbiter
   // ---------------------------------------------------------------------------
   logic       press_any;
   logic       all_released;
   logic [1:0] press_code;

   assign press_any    = rise_nickel | rise_dime | rise_clear;
   assign all_released = ~(level_nickel | level_dime | level_clear);
   assign press_code   = coin_priority(rise_nickel, rise_dime, rise_clear);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   enc_state_t state_q;
   enc_state_t state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: state_d is given a default before the case so that no path through
   // the block leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (press_any)    state_d = ST_EMIT;
         ST_EMIT:                   state_d = ST_HOLD;
         ST_HOLD: if (all_released) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // Outputs are decoded from the next state and registered, so coin_code is
   // glitch-free and valid for exactly the cycle the FSM spends in EMIT, and
   // busy tracks HOLD with no extra lag on release.
   // ---------------------------------------------------------------------------
   logic [1:0] coin_code_d;
   logic       busy_d;

   always_comb begin
      coin_code_d = CODE_IDLE;
      busy_d      = 1'b0;
      case (state_d)
         // EMIT is entered only from IDLE on a press, so press_code is the
         // arbitrated code of that press; the output register latches it.
         ST_EMIT: coin_code_d = press_code;
         ST_HOLD: busy_d      = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coin_code <= CODE_IDLE;
         busy      <= 1'b0;
      end else begin
         coin_code <= coin_code_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_coin_input_encoder.sv
// -----------------------------------------------------------------------------
// tb_coin_input_encoder
// Directed bench for coin_input_encoder with DEBOUNCE_CYCLES = 4.
// Stimulus is written in logical (pressed = 1) terms and mapped onto the pins
// according to COIN_ENC_ACTIVE_LOW_EN, so the same sequence covers both builds.
// Expected latency: button first sampled at edge N -> code after edge N+7.
// -----------------------------------------------------------------------------
module tb_coin_input_encoder;

   localparam int DB = 4;

`ifdef COIN_ENC_ACTIVE_LOW_EN
   localparam logic ACT_LOW = 1'b1;
`else
   localparam logic ACT_LOW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       nickel, dime, clr;
   logic       btn_nickel, btn_dime, btn_clear;
   logic [1:0] coin_code;
   logic       busy;

   int total = 0;
   int bad   = 0;

   assign btn_nickel = nickel ^ ACT_LOW;
   assign btn_dime   = dime   ^ ACT_LOW;
   assign btn_clear  = clr    ^ ACT_LOW;

   always #5 clk = ~clk;

   coin_input_encoder #(
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_nickel (btn_nickel),
      .btn_dime   (btn_dime),
      .btn_clear  (btn_clear),
      .coin_code  (coin_code),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Runs n cycles, sampling 1 time unit after each rising edge. Offsets count
   // from 0 = the first edge after the call. -1 means "never seen".
   task automatic watch(input int n, output int first, output logic [1:0] code,
                        output int pulses, output int busy_on, output int busy_off);
      first    = -1;
      code     = 2'b00;
      pulses   = 0;
      busy_on  = -1;
      busy_off = -1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (coin_code !== 2'b00) begin
            pulses++;
            if (first < 0) begin
               first = i;
               code  = coin_code;
            end
         end
         if (busy === 1'b1 && busy_on  < 0) busy_on  = i;
         if (busy === 1'b0 && busy_off < 0) busy_off = i;
      end
   endtask

   initial begin
      int         first, pulses, bon, boff, bounce_codes;
      logic [1:0] code;

      // ---------------- reset with all buttons idle ----------------
      nickel = 1'b0; dime = 1'b0; clr = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_code", coin_code, 2'b00);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;
      watch(15, first, code, pulses, bon, boff);
      check("idle_pulses", pulses, 0);
      check("idle_busy_on", bon, -1);

      // ---------------- clean dime press, held 20 cycles ----------------
      dime = 1'b1;
      watch(20, first, code, pulses, bon, boff);
      check("dime_latency", first, 7);
      check("dime_code", code, 2'b10);
      check("dime_pulses", pulses, 1);
      check("dime_busy_rise", bon, 8);
      dime = 1'b0;
      watch(12, first, code, pulses, bon, boff);
      check("dime_release_pulses", pulses, 0);
      check("dime_busy_fall", boff, 6);

      // ---------------- bouncing nickel, then stable ----------------
      bounce_codes = 0;
      for (int k = 0; k < 4; k++) begin
         nickel = (k % 2 == 0);
         @(posedge clk);
         #1;
         if (coin_code !== 2'b00) bounce_codes++;
      end
      check("bounce_no_code", bounce_codes, 0);
      nickel = 1'b1;
      watch(15, first, code, pulses, bon, boff);
      check("bounce_latency", first, 7);
      check("bounce_code", code, 2'b01);
      check("bounce_pulses", pulses, 1);
      nickel = 1'b0;
      watch(12, first, code, pulses, bon, boff);

      // ---------------- simultaneous presses ----------------
      nickel = 1'b1; dime = 1'b1;
      watch(20, first, code, pulses, bon, boff);
      check("nd_latency", first, 7);
      check("nd_code", code, 2'b10);
      check("nd_pulses", pulses, 1);
      nickel = 1'b0; dime = 1'b0;
      watch(12, first, code, pulses, bon, boff);

      clr = 1'b1; dime = 1'b1;
      watch(20, first, code, pulses, bon, boff);
      check("cd_code", code, 2'b11);
      check("cd_pulses", pulses, 1);
      clr = 1'b0; dime = 1'b0;
      watch(12, first, code, pulses, bon, boff);

      clr = 1'b1;
      watch(15, first, code, pulses, bon, boff);
      check("clear_latency", first, 7);
      check("clear_code", code, 2'b11);
      clr = 1'b0;
      watch(12, first, code, pulses, bon, boff);
      check("clear_release_busy_fall", boff, 6);

      // ---------------- press during HOLD is ignored ----------------
      nickel = 1'b1;
      watch(12, first, code, pulses, bon, boff);
      check("hold_first_code", code, 2'b01);
      dime = 1'b1;
      watch(15, first, code, pulses, bon, boff);
      check("hold_dime_pulses", pulses, 0);
      check("hold_busy_kept", busy, 1'b1);
      nickel = 1'b0; dime = 1'b0;
      watch(12, first, code, pulses, bon, boff);
      check("hold_release_pulses", pulses, 0);
      check("hold_release_busy_fall", boff, 6);
      nickel = 1'b1;
      watch(12, first, code, pulses, bon, boff);
      check("after_hold_latency", first, 7);
      check("after_hold_code", code, 2'b01);
      check("after_hold_pulses", pulses, 1);
      nickel = 1'b0;
      watch(12, first, code, pulses, bon, boff);

      // ---------------- reset mid-debounce, button kept held ----------------
      dime = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid_code", coin_code, 2'b00);
      check("rst_mid_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      watch(15, first, code, pulses, bon, boff);
      check("rst_mid_latency", first, 7);
      check("rst_mid_code_after", code, 2'b10);
      check("rst_mid_pulses", pulses, 1);
      dime = 1'b0;
      watch(12, first, code, pulses, bon, boff);

      // ---------------- reset during EMIT, button kept held ----------------
      nickel = 1'b1;
      watch(7, first, code, pulses, bon, boff);
      check("emit_pre_pulses", pulses, 0);
      @(posedge clk);
      #1;
      check("emit_code_before_rst", coin_code, 2'b01);
      #2;
      rst = 1'b1;
      #1;
      check("rst_emit_code", coin_code, 2'b00);
      check("rst_emit_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      watch(15, first, code, pulses, bon, boff);
      check("rst_emit_latency", first, 7);
      check("rst_emit_code_after", code, 2'b01);
      check("rst_emit_pulses", pulses, 1);
      nickel = 1'b0;
      watch(12, first, code, pulses, bon, boff);
      check("final_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
